// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, dark pattern and scan state type for the 7-segment scan driver.
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;
    localparam logic [6:0] SEG_OOR   = 7'b0001001;
    localparam logic [6:0] SEG_DARK  = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit code to active-low 7-segment pattern.
// SEG7_HEX_EN: codes 10..15 render A..F; otherwise they render the "H" out-of-range marker.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OOR;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10:   seg = SEG_HEX_A;
            4'd11:   seg = SEG_HEX_B;
            4'd12:   seg = SEG_HEX_C;
            4'd13:   seg = SEG_HEX_D;
            4'd14:   seg = SEG_HEX_E;
            4'd15:   seg = SEG_HEX_F;
`endif
            default: seg = SEG_OOR;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with dead time and frame-synchronous shadow data.
// SEG7_HEX_EN (via seg7_decode) selects hex glyphs for codes 10..15.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    // With no dead time every slot starts directly in SHOW
    localparam scan_state_e SLOT_START = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

    scan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic [4*DIGITS-1:0]  active_q, active_d;
    logic [6:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    an_q, an_d;

    logic [4*DIGITS-1:0]  reload_val;
    logic [3:0]           cur_code;
    logic                 cur_en;
    logic                 lit;
    logic [6:0]           dec_seg;

    assign reload_val = load ? data : shadow_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        active_d = active_q;
        shadow_d = load ? data : shadow_q;
        if (!ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = SLOT_START;
                    cnt_d    = '0;
                    idx_d    = '0;
                    active_d = reload_val;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = SLOT_START;
                        cnt_d   = '0;
                        // Displayed data only changes at frame wrap, so a load never tears a frame
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            active_d = reload_val;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cur_code = '0;
        cur_en   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_code = active_q[4*k +: 4];
                cur_en   = dig_en[k];
            end
        end
    end

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // Gating with ena makes the display go dark on the same edge that enters IDLE
    always_comb begin
        lit   = ena && (state_q == ST_SHOW) && cur_en;
        seg_d = lit ? dec_seg : SEG_DARK;
        an_d  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = !(lit && (idx_q == IDX_W'(k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            seg_q    <= SEG_DARK;
            an_q     <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots, 2 dead cycles).
module tb_seg7_scan_driver;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = SCAN_DIV + BLANK_CYC;
    localparam int FRAME     = DIGITS * SLOT;
    localparam int FIRST_LIT = 1 + BLANK_CYC + 1;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        ena    = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] data   = 16'h0000;
    logic [3:0]  dig_en = 4'hF;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .load   (load),
        .data   (data),
        .dig_en (dig_en),
        .seg    (seg),
        .an     (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] ref_decode(input logic [3:0] c);
        case (c)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
`ifdef SEG7_HEX_EN
            4'd10: return 7'b0001000;
            4'd11: return 7'b0000011;
            4'd12: return 7'b1000110;
            4'd13: return 7'b0100001;
            4'd14: return 7'b0000110;
            4'd15: return 7'b0001110;
`endif
            default: return 7'b0001001;
        endcase
    endfunction

    // k = negedges since ena was raised (or reset released with ena high)
    task automatic check_cycle(input int k, input logic [15:0] val, input string tag);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int p, slot;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        if (k >= FIRST_LIT) begin
            p    = (k - FIRST_LIT) % FRAME;
            slot = p / SLOT;
            if ((p % SLOT) < SCAN_DIV && dig_en[slot]) begin
                exp_an[slot] = 1'b0;
                exp_seg      = ref_decode(val[4*slot +: 4]);
            end
        end
        check($sformatf("%s_an_k%0d", tag, k), {28'd0, an}, {28'd0, exp_an});
        check($sformatf("%s_seg_k%0d", tag, k), {25'd0, seg}, {25'd0, exp_seg});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_an", {28'd0, an}, 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_seg", {25'd0, seg}, 32'h7F);
        check("idle_an", {28'd0, an}, 32'hF);

        data = 16'h1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        data = 16'h0000;
        ena  = 1'b1;

        // Frame 0 shows 1234 despite a mid-frame load; frames 1-3 show 5678; frame 2 has digit 2 disabled
        for (int k = 1; k <= FIRST_LIT - 1 + 3*FRAME + 14; k++) begin
            @(negedge clk);
            check_cycle(k, (k < FIRST_LIT + FRAME) ? 16'h1234 : 16'h5678, "scan");
            if (k == 10) begin
                data = 16'h5678;
                load = 1'b1;
            end
            if (k == 11) begin
                load = 1'b0;
                data = 16'h0000;
            end
            if (k == FIRST_LIT - 1 + 2*FRAME) dig_en = 4'b1011;
            if (k == FIRST_LIT - 1 + 3*FRAME) dig_en = 4'hF;
        end

        // Dropped while digit 2 is lit
        check("pre_drop_an", {28'd0, an}, 32'hB);
        ena = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check($sformatf("ena_off_seg_%0d", j), {25'd0, seg}, 32'h7F);
            check($sformatf("ena_off_an_%0d", j), {28'd0, an}, 32'hF);
        end

        ena = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_cycle(k, 16'h5678, "restart");
        end

        // Asynchronous reset in the middle of digit 0's slot
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", {25'd0, seg}, 32'h7F);
        check("async_rst_an", {28'd0, an}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= FIRST_LIT - 1 + FRAME; k++) begin
            @(negedge clk);
            check_cycle(k, 16'h0000, "post_rst");
        end

        // Load coincident with start: active must come straight from data
        ena = 1'b0;
        @(negedge clk);
        data = 16'hEDA9;
        load = 1'b1;
        ena  = 1'b1;
        for (int k = 1; k <= FIRST_LIT - 1 + FRAME; k++) begin
            @(negedge clk);
            check_cycle(k, 16'hEDA9, "hex");
            if (k == 1) begin
                load = 1'b0;
                data = 16'h0000;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of multiplexed digits (legal range 1..8).
REQ-002 Parameter SCAN_DIV, default 50000, sets the clock cycles each digit is lit per slot (minimum 1).
REQ-003 Parameter BLANK_CYC, default 16, sets the dead-time cycles with all digits dark before each slot (0 = no dead time).
REQ-004 Port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port ena, input, 1 bit: scanning enable; low = display dark.
REQ-007 Port load, input, 1 bit: single-cycle strobe that captures data into the shadow register.
REQ-008 Port data, input, 4*DIGITS bits: digit codes, digit k in data[4k+3:4k].
REQ-009 Port dig_en, input, DIGITS bits: per-digit enable, sampled live.
REQ-010 Port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 Port an, output, DIGITS bits: active-low digit selects, at most one low, registered.

Function
REQ-012 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-013 Dark output: seg=1111111 and an all ones.
REQ-014 States: IDLE, BLANK, SHOW.
REQ-015 IDLE: outputs dark; ena=1 -> BLANK with idx=0 and the active register loaded from shadow (or from data if load is high that cycle).
REQ-016 BLANK: outputs dark for exactly BLANK_CYC cycles, then SHOW; BLANK_CYC=0 goes straight to SHOW.
REQ-017 SHOW: for exactly SCAN_DIV cycles, an[idx]=0 and seg = decode of active digit idx; then idx advances and the state returns to BLANK.
REQ-018 idx wraps from DIGITS-1 to 0; on wrap, active is reloaded from shadow (data if load is high the same cycle).
REQ-019 A digit with dig_en[idx]=0 keeps its SHOW slot length but stays dark, so frame timing is constant.
REQ-020 Frame period is DIGITS*(SCAN_DIV+BLANK_CYC) cycles.
REQ-021 load updates shadow the next edge; displayed digits change only at wrap (no mid-frame tearing).
REQ-022 ena low in any state -> IDLE the next edge, idx=0, outputs dark; shadow is retained.
REQ-023 The counters are sized with $clog2 and never exceed their terminal value.
REQ-024 Output latency: ena rise at edge t -> digit 0 lit from edge t+1+BLANK_CYC.

Reset
REQ-025 rst_n low asynchronously forces IDLE, idx=0, counters=0, shadow=0, active=0, seg=1111111 and an all ones.
REQ-026 Reset deassertion is synchronous to clk; the first state change occurs no earlier than the first edge after release.

Configuration
REQ-027 Macro SEG7_HEX_EN defined: codes 10..15 give A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-028 Macro SEG7_HEX_EN undefined: codes 10..15 all give 0001001 ("H", out-of-range marker).

Structure
REQ-029 Package seg7_pkg holds the segment code constants, the dark pattern, and the state enum typedef.
REQ-030 The combinational decoder is a sub-module seg7_decode (4-bit code in, 7-bit pattern out, honours SEG7_HEX_EN).

Verification
REQ-031 DIGITS=4, SCAN_DIV=4, BLANK_CYC=2, load data=16'h1234, ena=1 -> an cycles 1110,1101,1011,0111 with seg 1111001,0100100,0110000,0011001; 2 dark cycles between slots; 24-cycle frame.
REQ-032 load 16'h5678 mid-frame -> the remainder of the frame still shows 1234; the next frame shows 5678.
REQ-033 dig_en=4'b1011 -> digit 2 slot dark for 4 cycles; the other slots and the frame period are unchanged.
REQ-034 ena dropped during SHOW of digit 2 -> dark the next cycle; ena re-raised -> digit 0 lit after 1+2 cycles.
REQ-035 Digit code 4'hA with SEG7_HEX_EN -> seg=0001000; without SEG7_HEX_EN -> seg=0001001.
REQ-036 rst_n pulsed low mid-SHOW -> seg=1111111 and an=1111 immediately (asynchronously); after release, shadow reads 0 and a restart shows "0000".
